// File: rtl/lector_mem_if.sv
// lector_mem_if: bundles the start request, memory read bus, output stream
// and status signals of the lector_mem block-read engine.
// master: the engine itself. slave: the memory/consumer/controller side.
interface lector_mem_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic            inicio;
  logic [AW-1:0]   dir_base;
  logic [AW-1:0]   longitud;
  logic [AW-1:0]   direccion;
  logic [DW-1:0]   dato;
  logic [DW-1:0]   dato_out;
  logic            valido;
  logic            listo;
  logic            ocupado;
  logic            fin;
  logic [2*DW-1:0] suma;

  modport master (
    input  inicio, dir_base, longitud, dato, listo,
    output direccion, dato_out, valido, ocupado, fin, suma
  );

  modport slave (
    output inicio, dir_base, longitud, dato, listo,
    input  direccion, dato_out, valido, ocupado, fin, suma
  );
endinterface

// File: rtl/lector_mem.sv
// lector_mem: sequential block-read engine for synchronous-read memories.
// Walks 'longitud' consecutive addresses from 'dir_base', captures each word
// one cycle after the memory samples the address, and offers it on a
// valid/ready stream. Each word costs at least three cycles (LEER, CAPTURA,
// ENTREGA).
// Optional feature macro: LECTOR_SUMA_EN enables the running-sum accumulator;
// without it 'suma' is tied to zero.
module lector_mem #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  lector_mem_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEER    = 2'd1,
    CAPTURA = 2'd2,
    ENTREGA = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] direccion_q, direccion_d;
  logic [AW-1:0] cuenta_q, cuenta_d;
  logic [DW-1:0] dato_out_q, dato_out_d;
  logic          valido_q, valido_d;
  logic          ocupado_q, ocupado_d;
  logic          fin_q, fin_d;

  logic          ultimo;
  logic          acepta;

  // The word being handed over is the last one of the burst.
  assign ultimo = (cuenta_q == AW'(1));
  // A start request is only honoured while idle.
  assign acepta = (state == IDLE) && bus.inicio;

  // State register; reset aborts any burst without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fixed LEER->CAPTURA->ENTREGA walk, ENTREGA waits on listo.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.inicio && (bus.longitud != '0)) begin
          state_next = LEER;
        end
      end
      LEER:    state_next = CAPTURA;
      CAPTURA: state_next = ENTREGA;
      ENTREGA: begin
        if (bus.listo) begin
          state_next = ultimo ? IDLE : LEER;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values for the registered address, data and status.
  always_comb begin
    direccion_d = direccion_q;
    cuenta_d    = cuenta_q;
    dato_out_d  = dato_out_q;
    valido_d    = valido_q;
    ocupado_d   = ocupado_q;
    fin_d       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.inicio) begin
          if (bus.longitud != '0) begin
            direccion_d = bus.dir_base;
            cuenta_d    = bus.longitud;
            ocupado_d   = 1'b1;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      CAPTURA: begin
        dato_out_d = bus.dato;
        valido_d   = 1'b1;
      end
      ENTREGA: begin
        if (bus.listo) begin
          valido_d = 1'b0;
          cuenta_d = cuenta_q - AW'(1);
          if (ultimo) begin
            fin_d     = 1'b1;
            ocupado_d = 1'b0;
          end else begin
            direccion_d = direccion_q + AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      direccion_q <= '0;
      cuenta_q    <= '0;
      dato_out_q  <= '0;
      valido_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      direccion_q <= direccion_d;
      cuenta_q    <= cuenta_d;
      dato_out_q  <= dato_out_d;
      valido_q    <= valido_d;
      ocupado_q   <= ocupado_d;
      fin_q       <= fin_d;
    end
  end

  assign bus.direccion = direccion_q;
  assign bus.dato_out  = dato_out_q;
  assign bus.valido    = valido_q;
  assign bus.ocupado   = ocupado_q;
  assign bus.fin       = fin_q;

`ifdef LECTOR_SUMA_EN
  logic [2*DW-1:0] suma_q;

  // Running sum: cleared by any accepted start (including zero length),
  // grows as each word is captured, and holds after the burst ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      suma_q <= '0;
    end else if (acepta) begin
      suma_q <= '0;
    end else if (state == CAPTURA) begin
      suma_q <= suma_q + {{DW{1'b0}}, bus.dato};
    end
  end

  assign bus.suma = suma_q;
`else
  logic unused_acepta;
  assign unused_acepta = acepta;
  assign bus.suma      = '0;
`endif

endmodule

// File: tb/tb_lector_mem.sv
// tb_lector_mem: directed and randomized bursts against a 256-entry
// synchronous ROM; expected words, addresses, sums and cycle timing come from
// a plain model of the ROM contents and burst rules.
module tb_lector_mem;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk;
  logic rst;

  int tests;
  int failed;
  logic [15:0] last_sum;

  logic [7:0] rom [256];

  lector_mem_if #(.AW(AW), .DW(DW)) bus_if ();

  lector_mem #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: address sampled on the rising edge, data the cycle after.
  always @(posedge clk) bus_if.dato <= rom[bus_if.direccion];

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef LECTOR_SUMA_EN
    return s;
`else
    return 16'd0 & s;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Optionally disturb the idle-only inputs while a burst is running.
  task automatic poke(input bit en);
    if (en) begin
      bus_if.inicio   = 1'($urandom_range(0, 1));
      bus_if.dir_base = 8'd5;
      bus_if.longitud = 8'($urandom);
    end
  endtask

  // Start a burst and follow it to the final handshake (fin high on return).
  task automatic apply_stimulus(input logic [7:0] base, input logic [7:0] len,
                                input int stall_first, input bit rnd);
    logic [15:0] sum;
    logic [7:0]  a;
    logic [7:0]  held;
    int          n;
    int          stalls;
    sum = 16'd0;
    bus_if.inicio   = 1'b1;
    bus_if.dir_base = base;
    bus_if.longitud = len;
    bus_if.listo    = 1'b1;
    step();
    bus_if.inicio = 1'b0;
    if (len == 8'd0) begin
      check_output("zero_fin", bus_if.fin, 1);
      check_output("zero_ocupado", bus_if.ocupado, 0);
      check_output("zero_valido", bus_if.valido, 0);
      check_output("zero_suma", bus_if.suma, exp_sum(16'd0));
      last_sum = 16'd0;
      return;
    end
    check_output("start_ocupado", bus_if.ocupado, 1);
    check_output("start_dir", bus_if.direccion, base);
    check_output("start_valido", bus_if.valido, 0);
    for (int i = 0; i < int'(len); i++) begin
      a = base + 8'(i);
      n = 0;
      while (!bus_if.valido && n < 10) begin
        poke(rnd);
        step();
        n++;
      end
      bus_if.inicio = 1'b0;
      check_output("latency", n, 2);
      if (n >= 10) return;
      sum = sum + {8'd0, rom[a]};
      check_output("dato", bus_if.dato_out, rom[a]);
      check_output("dir", bus_if.direccion, a);
      check_output("suma", bus_if.suma, exp_sum(sum));
      check_output("fin_mid", bus_if.fin, 0);
      held   = bus_if.dato_out;
      stalls = (i == 0) ? stall_first : (rnd ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < stalls; s++) begin
        bus_if.listo = 1'b0;
        poke(rnd);
        step();
        check_output("hold_valido", bus_if.valido, 1);
        check_output("hold_dato", bus_if.dato_out, held);
      end
      bus_if.inicio = 1'b0;
      bus_if.listo  = 1'b1;
      step();
      check_output("hs_valido", bus_if.valido, 0);
      if (i == int'(len) - 1) begin
        check_output("end_fin", bus_if.fin, 1);
        check_output("end_ocupado", bus_if.ocupado, 0);
      end else begin
        check_output("next_fin", bus_if.fin, 0);
        check_output("next_ocupado", bus_if.ocupado, 1);
        check_output("next_dir", bus_if.direccion, 8'(a + 8'd1));
      end
    end
    last_sum = sum;
  endtask

  // One idle cycle after a burst: fin drops, sum holds.
  task automatic check_idle();
    step();
    check_output("idle_fin", bus_if.fin, 0);
    check_output("idle_ocupado", bus_if.ocupado, 0);
    check_output("idle_valido", bus_if.valido, 0);
    check_output("idle_suma", bus_if.suma, exp_sum(last_sum));
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    last_sum = 16'd0;
    for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
    rom[0] = 8'd90; rom[1] = 8'd80; rom[2] = 8'd70; rom[3] = 8'd60;
    rom[4] = 8'd50; rom[5] = 8'd40; rom[6] = 8'd30; rom[7] = 8'd20;
    rom[8] = 8'd10; rom[9] = 8'd1;  rom[10] = 8'd100; rom[255] = 8'd7;

    rst             = 1'b1;
    bus_if.inicio   = 1'b0;
    bus_if.dir_base = 8'd0;
    bus_if.longitud = 8'd0;
    bus_if.listo    = 1'b0;
    #12;
    check_output("rst_direccion", bus_if.direccion, 0);
    check_output("rst_dato_out", bus_if.dato_out, 0);
    check_output("rst_valido", bus_if.valido, 0);
    check_output("rst_ocupado", bus_if.ocupado, 0);
    check_output("rst_fin", bus_if.fin, 0);
    check_output("rst_suma", bus_if.suma, 0);
    rst = 1'b0;
    step();

    // Basic burst: 90, 80, 70 -> 240.
    apply_stimulus(8'd0, 8'd3, 0, 1'b0);
    check_output("basic_sum", {16'd0, last_sum}, 240);
    check_idle();

    // Backpressure on the first word: 10 held, then 1, 100 -> 111.
    apply_stimulus(8'd8, 8'd3, 4, 1'b0);
    check_idle();

    // Zero length.
    apply_stimulus(8'd4, 8'd0, 0, 1'b0);
    check_idle();

    // Address wrap: 7 then 90 -> 97.
    apply_stimulus(8'd255, 8'd2, 0, 1'b0);
    check_idle();

    // Start requests during a burst are ignored.
    apply_stimulus(8'd0, 8'd3, 2, 1'b1);
    check_idle();

    // Back-to-back: next start accepted while fin is high.
    apply_stimulus(8'd1, 8'd2, 0, 1'b0);
    apply_stimulus(8'd6, 8'd3, 0, 1'b0);
    check_idle();

    // Reset while waiting in ENTREGA.
    bus_if.inicio   = 1'b1;
    bus_if.dir_base = 8'd0;
    bus_if.longitud = 8'd3;
    step();
    bus_if.inicio = 1'b0;
    bus_if.listo  = 1'b0;
    step();
    step();
    check_output("pre_rst_valido", bus_if.valido, 1);
    #3;
    rst = 1'b1;
    #1;
    check_output("mid_rst_valido", bus_if.valido, 0);
    check_output("mid_rst_ocupado", bus_if.ocupado, 0);
    check_output("mid_rst_suma", bus_if.suma, 0);
    check_output("mid_rst_fin", bus_if.fin, 0);
    rst          = 1'b0;
    bus_if.listo = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("post_rst_fin", bus_if.fin, 0);
      check_output("post_rst_ocupado", bus_if.ocupado, 0);
    end
    apply_stimulus(8'd0, 8'd3, 0, 1'b0);
    check_idle();

    // Randomized bursts.
    for (int r = 0; r < 8; r++) begin
      apply_stimulus(8'($urandom), 8'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)), 1'b1);
      check_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lector_mem.md
# lector_mem

Sequential block-read engine: the initiator side of the team's synchronous-read memories (`srom`-style: address sampled on `posedge clk`, data valid the following cycle). On a start pulse it walks `longitud` consecutive addresses from `dir_base` and captures each returned word. It presents each word on a valid/ready output stream with backpressure, and accumulates a running sum. It sits between a synchronous ROM/RAM instance and any consumer that needs a table streamed out in order.

## Interface
Parameters:
- `AW`, 8, address width; drives `direccion`, `dir_base`, `longitud`.
- `DW`, 8, data word width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inicio`  in  1  start request; sampled only in `IDLE`.
- `dir_base`  in  AW  first address; sampled with `inicio`.
- `longitud`  in  AW  word count; sampled with `inicio`; 0 is legal.
- `direccion`  out  AW  registered address to memory.
- `dato`  in  DW  memory read data; valid one cycle after `direccion` is sampled.
- `dato_out`  out  DW  captured word.
- `valido`  out  1  `dato_out` valid.
- `listo`  in  1  consumer ready.
- `ocupado`  out  1  burst in progress.
- `fin`  out  1  one-cycle pulse on burst completion.
- `suma`  out  2*DW  running sum of words delivered in the current burst.

## Operation
- States: `IDLE`, `LEER`, `CAPTURA`, `ENTREGA`.
- `IDLE`, `inicio`=1, `longitud`≠0:
  - `direccion`<=`dir_base`, `cuenta`<=`longitud`, `suma`<=0, `ocupado`<=1.
  - Next state `LEER`.
- `IDLE`, `inicio`=1, `longitud`=0:
  - `fin`<=1 for one cycle; `suma`<=0.
  - Stays in `IDLE`; no reads; `ocupado` stays 0.
- `LEER`: memory samples `direccion` at this edge; next state `CAPTURA`.
- `CAPTURA`:
  - `dato_out`<=`dato`, `valido`<=1.
  - `suma`<=`suma`+zero-extended `dato`.
  - Next state `ENTREGA`.
- `ENTREGA`: hold `valido`=1 and `dato_out` stable until an edge with `listo`=1. At that edge:
  - `valido`<=0, `cuenta`<=`cuenta`-1.
  - If `cuenta`=1: `fin`<=1, `ocupado`<=0, next state `IDLE`.
  - Otherwise: `direccion`<=`direccion`+1, next state `LEER`.
- `inicio` outside `IDLE` is ignored. `dir_base` and `longitud` changes mid-burst have no effect.
- `direccion` increments modulo 2^AW (255→0 at AW=8).
- `suma` width 2*DW cannot overflow for `longitud` ≤ 2^AW−1 at AW=DW. It holds its value after `fin` until the next accepted `inicio`.
- Reset values (async, any state):
  - State `IDLE`.
  - `direccion`, `dato_out`, `suma` = 0.
  - `valido`, `ocupado`, `fin` = 0.
  - `cuenta` = 0.
- A reset mid-burst aborts the burst without a `fin` pulse.

## Timing
- Edge E0 accepts `inicio`. The memory samples `dir_base` at E1. `valido` rises after E2.
- First-word latency is 2 cycles from the accepting edge.
- Minimum 3 cycles per word with `listo` held high.
- `fin` is high for exactly the cycle after the final handshake edge. `ocupado` falls at the same edge.
- A new `inicio` is accepted on the edge after `fin` rises, i.e. while `fin` is high.
- `valido` never deasserts without a handshake, except on reset.
- `dato_out` is stable while `valido`=1 and `listo`=0.

## Configuration
- `LECTOR_SUMA_EN` defined: the `suma` accumulator is present as described.
- `LECTOR_SUMA_EN` undefined: the accumulator is removed and `suma` is driven constant 0. All other behaviour and timing are identical.

## Test plan
Memory model: 256-entry synchronous ROM. Entries 0..10 = 90,80,70,60,50,40,30,20,10,1,100. Entry 255 = 7.
- Basic burst: `dir_base`=0, `longitud`=3, `listo`=1.
  - Expect `dato_out` 90, 80, 70, each `valido` for 1 cycle, 3 cycles apart.
  - First `valido` 2 cycles after `inicio`.
  - `suma`=240; `fin` pulse 1 cycle; `ocupado` low after it.
- Backpressure: `dir_base`=8, `longitud`=3, `listo` low for 4 cycles on the first word.
  - Expect 10 held stable for 5 valid cycles, then 1, then 100.
  - `suma`=111.
- Zero length: `longitud`=0.
  - Expect `fin` for one cycle after E0.
  - `valido` never set, `ocupado` stays 0, `suma`=0.
- Wrap: `dir_base`=255, `longitud`=2.
  - Expect `direccion` 255 then 0; words 7 then 90.
  - `suma`=97.
- Ignored start: pulse `inicio` with `dir_base`=5 during a burst from 0.
  - Expect the burst from 0 to complete unchanged.
- Reset mid-burst: assert `rst` while in `ENTREGA`.
  - Expect immediate `valido`=`ocupado`=0, `suma`=0, no `fin`.
  - A following burst behaves as the basic burst.
